ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-master arbiter that shares one port of the dual-port `ram` between two requesters, for example the core data port and a debug/DMA master. Each cycle it grants at most one request using round-robin priority, with an optional lock for atomic sequences. It drives the RAM port directly and returns a one-cycle-latency response (`rvalid` plus read data) to the granted master. It sits between the masters and `ram_interface` port B.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width, passed through to the RAM unchanged.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.

Ports (x = 0, 1):
- `clk_i`  in  1: clock; the RAM runs on the same clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `mx_req_i`  in  1: request from master x; held until granted.
- `mx_lock_i`  in  1: keep ownership of the port after this grant.
- `mx_addr_i`  in  ADDR_WIDTH: request address.
- `mx_we_i`  in  DATA_WIDTH/8: byte write enables; all-zero means read.
- `mx_wdata_i`  in  DATA_WIDTH: write data.
- `mx_gnt_o`  out  1: request accepted this cycle; combinational.
- `mx_rvalid_o`  out  1: response for the previous-cycle grant.
- `mx_rdata_o`  out  DATA_WIDTH: read data; valid when `mx_rvalid_o` is high.
- `ram_en_o`  out  1: RAM port enable.
- `ram_addr_o`  out  ADDR_WIDTH: RAM address.
- `ram_we_o`  out  DATA_WIDTH/8: RAM byte write enables.
- `ram_wdata_o`  out  DATA_WIDTH: RAM write data.
- `ram_rdata_i`  in  DATA_WIDTH: RAM read data, valid one cycle after `ram_en_o`.

## Operation
Registered state:
- `prio`: 0 or 1, the master that wins a tie.
- `owner`: NONE, M0 or M1; the master that holds the lock.
- `rsp_v`: 1 bit, a response is due this cycle.
- `rsp_id`: 0 or 1, the master the response belongs to.

Grant rule, combinational, evaluated every cycle:
- `owner` = Mx: only master x can be granted. The other master's request stalls; `gnt` stays 0 for it.
- `owner` = NONE, one requester: that requester is granted.
- `owner` = NONE, both requesting: master `prio` is granted.
- At most one `gnt` is high in any cycle.

On a grant to master x:
- `ram_en_o` = 1.
- `ram_addr_o`, `ram_we_o` and `ram_wdata_o` are muxed from master x.
- No grant: `ram_en_o` = 0 and `ram_we_o` = 0. Address and wdata are don't-care but are driven from master 0.

State updates on a granted cycle:
- `prio` becomes 1-x.
- `owner` becomes Mx if `mx_lock_i` = 1, otherwise NONE.

State updates on every cycle:
- `rsp_v` is loaded with (any grant).
- `rsp_id` is loaded with x whenever a grant occurs.

Lock state machine:
- NONE → Mx: on a grant to x with lock = 1.
- Mx → NONE: on a grant to x with lock = 0.
- Mx with `mx_req_i` = 0: stays Mx. The owner holds the port indefinitely; releasing it is the master's responsibility.

Response:
- `mx_rvalid_o` = `rsp_v` && (`rsp_id` == x).
- `mx_rdata_o` = `ram_rdata_i` for both masters. It is qualified only by rvalid.
- Writes also return `rvalid` as a completion ack, with don't-care rdata.

## Timing
- Grant latency is zero: `gnt` is in the same cycle as `req` when the port is free.
- Response latency is exactly 1: `rvalid` is the cycle after `gnt`.
- Throughput: one transaction per cycle, back-to-back, including alternation between masters.
- Reset values:
  - `prio` = 0, `owner` = NONE, `rsp_v` = 0, `rsp_id` = 0.
  - All `gnt`, `rvalid` and `ram_en_o` are 0, and `ram_we_o` = 0.
- While `rst_ni` = 0, grants are forced to 0 combinationally.
- Reset asserted mid-transaction: a pending `rvalid` is dropped immediately and the lock is cleared. After reset release, the first tie goes to master 0.
- Simultaneous request and response: a new grant in the same cycle as a pending `rvalid` is legal. The response belongs to the previous cycle's grant.
- Request withdrawn before grant: legal. No state changes.

## Test plan
- Reset, then m0 read at `0x10` holding `0xDEADBEEF`: `m0_gnt_o` = 1 in cycle 0, `m0_rvalid_o` = 1 with `0xDEADBEEF` in cycle 1, `m1_rvalid_o` = 0.
- Both masters request continuously from reset: grants alternate m0, m1, m0, m1 for 4 cycles. Each `rvalid` goes to the master granted one cycle earlier, with no dead cycles.
- m1 writes `0xA5A5A5A5` with `we` = `4'b0011` at `0x20`, then m0 reads `0x20` (prior contents 0): m0 reads `0x0000A5A5`. m1 gets its write ack `rvalid` cycle-aligned.
- m0 makes 3 locked requests then an unlocked one while m1 requests throughout: m0 is granted 4 consecutive times, m1 is granted in the 5th cycle, and `m1_gnt_o` stays 0 for the first 4.
- Pull `rst_ni` low the cycle after an m1 grant while m0 holds the lock: `m1_rvalid_o` is 0 at once and `owner` = NONE. After release with both requesting, m0 is granted first.
- No requests for 10 cycles: `ram_en_o` = 0, `ram_we_o` = 0, and no `rvalid`.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
//
// One requester channel of the RAM port arbiter. Each master (core data
// port, debug/DMA engine) owns one instance.
//
//   req    master -> arbiter  request, held until granted
//   lock   master -> arbiter  keep ownership of the port after this grant
//   addr   master -> arbiter  request address
//   we     master -> arbiter  byte write enables, all-zero means read
//   wdata  master -> arbiter  write data
//   gnt    arbiter -> master  request accepted this cycle (combinational)
//   rvalid arbiter -> master  response for the previous-cycle grant
//   rdata  arbiter -> master  read data, qualified by rvalid
//
// Modports:
//   master : the requester side
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    req;
  logic                    lock;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] we;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req,
    output lock,
    output addr,
    output we,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  lock,
    input  addr,
    input  we,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one port of the dual-port RAM between two masters. At most one
// request is granted per cycle using round-robin priority, with an optional
// lock that lets a master keep the port across an atomic sequence. The
// granted request is driven straight onto the RAM port, and the response
// (rvalid + read data) comes back to that master exactly one cycle later.
//
// Ports:
//   clk_i        clock, shared with the RAM
//   rst_ni       asynchronous active-low reset
//   m0, m1       requester channels (ram_port_arbiter_if.slave)
//   ram_en_o     RAM port enable
//   ram_addr_o   RAM address
//   ram_we_o     RAM byte write enables
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, valid one cycle after ram_en_o
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  ram_port_arbiter_if.slave       m0,
  ram_port_arbiter_if.slave       m1,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH/8-1:0] ram_we_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Lock owner encoding
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_M0   = 2'd1;
  localparam logic [1:0] OWNER_M1   = 2'd2;

  // Registered state
  logic       prio;     // master that wins a tie
  logic [1:0] owner;    // master holding the lock, if any
  logic       rsp_v;    // a response is due this cycle
  logic       rsp_id;   // master the due response belongs to

  // Grant decode
  logic owned_by_m0;
  logic owned_by_m1;
  logic port_free;
  logic gnt_m0;
  logic gnt_m1;
  logic grant_any;
  logic grant_id;
  logic grant_lock;
  logic [1:0] owner_next;

  // The unused encoding 2'b11 is treated as a free port so a corrupted
  // owner register cannot wedge the arbiter forever.
  assign owned_by_m0 = (owner == OWNER_M0);
  assign owned_by_m1 = (owner == OWNER_M1);
  assign port_free   = !owned_by_m0 && !owned_by_m1;

  // A locked owner is the only master that can win. Otherwise a lone
  // requester wins, and a tie goes to prio. Reset masks every grant so
  // nothing reaches the RAM while rst_ni is low.
  assign gnt_m0 = rst_ni && m0.req &&
                  (owned_by_m0 || (port_free && (!m1.req || !prio)));
  assign gnt_m1 = rst_ni && m1.req &&
                  (owned_by_m1 || (port_free && (!m0.req ||  prio)));

  assign grant_any  = gnt_m0 || gnt_m1;
  assign grant_id   = gnt_m1;
  assign grant_lock = gnt_m1 ? m1.lock : m0.lock;

  always_comb begin
    owner_next = OWNER_NONE;
    if (grant_lock) begin
      owner_next = grant_id ? OWNER_M1 : OWNER_M0;
    end
  end

  assign m0.gnt = gnt_m0;
  assign m1.gnt = gnt_m1;

  // RAM port mux. Without a grant the address and wdata follow master 0
  // (they are ignored by the RAM), but enable and write enables are forced
  // low so an idle cycle can never write.
  always_comb begin
    ram_en_o    = grant_any;
    ram_addr_o  = gnt_m1 ? m1.addr  : m0.addr;
    ram_wdata_o = gnt_m1 ? m1.wdata : m0.wdata;
    ram_we_o    = {BE_WIDTH{1'b0}};
    if (grant_any) begin
      ram_we_o = gnt_m1 ? m1.we : m0.we;
    end
  end

  // Round-robin pointer, lock owner and response tracking. rsp_v is
  // reloaded every cycle so a response is only ever one cycle wide, and a
  // new grant can coexist with the response to the previous one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio   <= 1'b0;
      owner  <= OWNER_NONE;
      rsp_v  <= 1'b0;
      rsp_id <= 1'b0;
    end else begin
      rsp_v <= grant_any;
      if (grant_any) begin
        prio   <= ~grant_id;
        owner  <= owner_next;
        rsp_id <= grant_id;
      end
    end
  end

  // Responses are steered to the master granted last cycle. The read data
  // bus is shared; only rvalid distinguishes the recipient. Writes return
  // rvalid as a completion ack with meaningless rdata.
  assign m0.rvalid = rst_ni && rsp_v && !rsp_id;
  assign m1.rvalid = rst_ni && rsp_v &&  rsp_id;
  assign m0.rdata  = ram_rdata_i;
  assign m1.rdata  = ram_rdata_i;

  // Structural invariants
  a_single_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(gnt_m0 && gnt_m1));
  a_idle_no_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !ram_en_o |-> (ram_we_o == {BE_WIDTH{1'b0}}));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter. A small word-addressed RAM model
// with byte enables and one-cycle read latency sits on the RAM port.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 2 units later, well clear of either clock edge.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ram_en_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  ram_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();

  ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: read-before-write, byte-enabled writes, registered read data
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
      ram_rdata_i <= mem[ram_addr_o[9:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive both masters for the current cycle, then settle before sampling
  task automatic applyStimulus(
    input logic r0, input logic l0, input logic [31:0] a0,
    input logic [3:0] w0, input logic [31:0] d0,
    input logic r1, input logic l1, input logic [31:0] a1,
    input logic [3:0] w1, input logic [31:0] d1);
    m0_if.req = r0; m0_if.lock = l0; m0_if.addr = a0; m0_if.we = w0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.lock = l1; m1_if.addr = a1; m1_if.we = w1; m1_if.wdata = d1;
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic doReset();
    tick();
    rst_ni = 1'b0;
    idle();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;   // 0x10
    mem[12] = 32'h12345678;   // 0x30

    // Reset state, with a write request asserted to show it is masked
    rst_ni = 1'b0;
    applyStimulus(1, 0, 32'h10, 4'hF, 32'hFFFF_FFFF, 1, 0, 32'h30, 4'hF, 32'h0);
    checkOutput("rst_gnt0",   m0_if.gnt,    0);
    checkOutput("rst_gnt1",   m1_if.gnt,    0);
    checkOutput("rst_ram_en", ram_en_o,     0);
    checkOutput("rst_ram_we", ram_we_o,     0);
    checkOutput("rst_rv0",    m0_if.rvalid, 0);
    checkOutput("rst_rv1",    m1_if.rvalid, 0);
    tick();
    idle();
    tick();
    rst_ni = 1'b1;

    // Single read by m0
    tick();
    applyStimulus(1, 0, 32'h10, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    checkOutput("rd_gnt0",     m0_if.gnt,  1);
    checkOutput("rd_gnt1",     m1_if.gnt,  0);
    checkOutput("rd_ram_en",   ram_en_o,   1);
    checkOutput("rd_ram_addr", ram_addr_o, 32'h10);
    tick();
    idle();
    checkOutput("rd_rv0",   m0_if.rvalid, 1);
    checkOutput("rd_rdata", m0_if.rdata,  32'hDEADBEEF);
    checkOutput("rd_rv1",   m1_if.rvalid, 0);

    // Both requesting from reset: strict alternation m0, m1, m0, m1
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) applyStimulus(1, 0, 32'h10, 4'h0, 32'h0, 1, 0, 32'h30, 4'h0, 32'h0);
      else       idle();
      checkOutput("rr_gnt0", m0_if.gnt, (i < 4) && (i % 2 == 0));
      checkOutput("rr_gnt1", m1_if.gnt, (i < 4) && (i % 2 == 1));
      if (i == 0) begin
        checkOutput("rr_rv0_first", m0_if.rvalid, 0);
        checkOutput("rr_rv1_first", m1_if.rvalid, 0);
      end else begin
        checkOutput("rr_rv0", m0_if.rvalid, ((i - 1) % 2 == 0));
        checkOutput("rr_rv1", m1_if.rvalid, ((i - 1) % 2 == 1));
        checkOutput("rr_rdata", m0_if.rdata,
                    ((i - 1) % 2 == 0) ? 64'hDEADBEEF : 64'h12345678);
      end
    end

    // m1 partial write to 0x20, then m0 reads it back
    tick();
    applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h20, 4'b0011, 32'hA5A5A5A5);
    checkOutput("wr_gnt1",      m1_if.gnt,   1);
    checkOutput("wr_gnt0",      m0_if.gnt,   0);
    checkOutput("wr_ram_we",    ram_we_o,    4'b0011);
    checkOutput("wr_ram_wdata", ram_wdata_o, 32'hA5A5A5A5);
    checkOutput("wr_ram_addr",  ram_addr_o,  32'h20);
    tick();
    applyStimulus(1, 0, 32'h20, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    checkOutput("wr_rd_gnt0", m0_if.gnt,    1);
    checkOutput("wr_ack_rv1", m1_if.rvalid, 1);
    checkOutput("wr_rd_rv0",  m0_if.rvalid, 0);
    checkOutput("wr_rd_we",   ram_we_o,     0);
    tick();
    idle();
    checkOutput("wr_rb_rv0",   m0_if.rvalid, 1);
    checkOutput("wr_rb_rdata", m0_if.rdata,  32'h0000A5A5);
    checkOutput("wr_rb_rv1",   m1_if.rvalid, 0);

    // Locked sequence: 3 locked + 1 unlocked by m0, m1 requesting throughout
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(i < 4, i < 3, 32'h10, 4'h0, 32'h0, 1, 0, 32'h30, 4'h0, 32'h0);
      checkOutput("lk_gnt0", m0_if.gnt, i < 4);
      checkOutput("lk_gnt1", m1_if.gnt, i == 4);
      if (i > 0) checkOutput("lk_rv0", m0_if.rvalid, 1);
    end
    tick();
    idle();
    checkOutput("lk_rv1", m1_if.rvalid, 1);

    // Reset while m0 holds the lock and responses are in flight
    tick();
    applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h30, 4'h0, 32'h0);
    checkOutput("ra_gnt1", m1_if.gnt, 1);
    tick();
    applyStimulus(1, 1, 32'h10, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    checkOutput("ra_lock_gnt0", m0_if.gnt,    1);
    checkOutput("ra_rv1",       m1_if.rvalid, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h30, 4'h0, 32'h0);
    checkOutput("ra_stall_gnt1", m1_if.gnt,    0);
    checkOutput("ra_rv0",        m0_if.rvalid, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("ra_rv0_drop",   m0_if.rvalid, 0);
    checkOutput("ra_rv1_drop",   m1_if.rvalid, 0);
    checkOutput("ra_gnt1_rst",   m1_if.gnt,    0);
    checkOutput("ra_owner_none", dut.owner,    0);
    tick();
    tick();
    rst_ni = 1'b1;
    applyStimulus(1, 0, 32'h10, 4'h0, 32'h0, 1, 0, 32'h30, 4'h0, 32'h0);
    checkOutput("ra_tie_gnt0", m0_if.gnt, 1);
    checkOutput("ra_tie_gnt1", m1_if.gnt, 0);
    tick();
    idle();
    checkOutput("ra_tie_rv0", m0_if.rvalid, 1);

    // Quiet bus
    for (int i = 0; i < 10; i++) begin
      tick();
      idle();
      checkOutput("idle_ram_en", ram_en_o,     0);
      checkOutput("idle_ram_we", ram_we_o,     0);
      checkOutput("idle_rv0",    m0_if.rvalid, 0);
      checkOutput("idle_rv1",    m1_if.rvalid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
